// File: rtl/blink_pkg.sv
// Shared types and constants for the blinker frequency detector.
// Rate encoding matches the blinker's {switch1,switch2} select inputs.
package blink_pkg;

   localparam int unsigned CNT_W = 27;

   localparam int unsigned DIV_1HZ   = 1;
   localparam int unsigned DIV_10HZ  = 10;
   localparam int unsigned DIV_50HZ  = 50;
   localparam int unsigned DIV_100HZ = 100;

   typedef enum logic [1:0] {
      FREQ_1HZ   = 2'b00,
      FREQ_10HZ  = 2'b01,
      FREQ_50HZ  = 2'b10,
      FREQ_100HZ = 2'b11
   } freq_code_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ARMED,
      ST_CONFIRM,
      ST_LOCKED
   } det_state_t;

   // True when m lies within nominal +/- (nominal >> tol_shift), written to avoid underflow.
   function automatic logic in_band(input logic [31:0] m,
                                    input logic [31:0] nominal,
                                    input int unsigned tol_shift);
      logic [31:0] tol;
      tol = nominal >> tol_shift;
      return ((m + tol) >= nominal) && (m <= (nominal + tol));
   endfunction

endpackage

// File: rtl/blink_edge_sync.sv
// Synchronizes the asynchronous blinker input and emits a one-cycle rising-edge pulse.
// Optional BLINK_DET_DEGLITCH_EN adds a 3-sample majority-of-all filter (+2 cycles latency).
module blink_edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic sig_in,
   output logic edge_p
);

   logic [1:0] sync_q;
   logic       clean;
   logic       clean_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], sig_in};
      end
   end

`ifdef BLINK_DET_DEGLITCH_EN
   logic hist_q;
   logic filt_q;

   // Output follows only once three consecutive synchronized samples agree.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 1'b0;
         filt_q <= 1'b0;
      end else begin
         hist_q <= sync_q[1];
         if ((sync_q[0] == sync_q[1]) && (sync_q[1] == hist_q)) begin
            filt_q <= sync_q[1];
         end
      end
   end

   assign clean = filt_q;
`else
   assign clean = sync_q[1];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clean_d <= 1'b0;
         edge_p  <= 1'b0;
      end else begin
         clean_d <= clean;
         edge_p  <= clean & ~clean_d;
      end
   end

endmodule

// File: rtl/blink_freq_detect.sv
// Measures the rising-edge period of a blinker output and locks onto 1/10/50/100 Hz.
// Build option BLINK_DET_DEGLITCH_EN enables the input glitch filter in blink_edge_sync.
module blink_freq_detect
   import blink_pkg::*;
#(
   parameter int unsigned CLK_HZ    = 50_000_000,
   parameter int unsigned TOL_SHIFT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic             sig_in,
   output logic [1:0]       freq_code,
   output logic             freq_valid,
   output logic [CNT_W-1:0] period,
   output logic             lock_err
);

   localparam int unsigned P_1HZ   = CLK_HZ / DIV_1HZ;
   localparam int unsigned P_10HZ  = CLK_HZ / DIV_10HZ;
   localparam int unsigned P_50HZ  = CLK_HZ / DIV_50HZ;
   localparam int unsigned P_100HZ = CLK_HZ / DIV_100HZ;
   localparam int unsigned TIMEOUT = (3 * CLK_HZ) / 2;

   logic             edge_p;
   det_state_t       state;
   freq_code_t       cand;
   freq_code_t       code_q;
   freq_code_t       hit_code;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] meas;
   logic [3:0]       band_hit;
   logic             hit_any;
   logic             timeout;

   blink_edge_sync u_edge_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .sig_in (sig_in),
      .edge_p (edge_p)
   );

   // Period as it would be captured on this cycle's edge.
   assign meas    = cnt + CNT_W'(1);
   assign timeout = (32'(cnt) >= TIMEOUT);

   always_comb begin
      band_hit    = 4'b0000;
      band_hit[0] = in_band(32'(meas), P_1HZ,   TOL_SHIFT);
      band_hit[1] = in_band(32'(meas), P_10HZ,  TOL_SHIFT);
      band_hit[2] = in_band(32'(meas), P_50HZ,  TOL_SHIFT);
      band_hit[3] = in_band(32'(meas), P_100HZ, TOL_SHIFT);
   end

   // Bands are disjoint, so priority order only matters for the out-of-band default.
   always_comb begin
      hit_code = FREQ_1HZ;
      if (band_hit[1]) begin
         hit_code = FREQ_10HZ;
      end else if (band_hit[2]) begin
         hit_code = FREQ_50HZ;
      end else if (band_hit[3]) begin
         hit_code = FREQ_100HZ;
      end
   end

   assign hit_any   = |band_hit;
   assign freq_code = code_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         period     <= '0;
         cand       <= FREQ_1HZ;
         code_q     <= FREQ_1HZ;
         freq_valid <= 1'b0;
         lock_err   <= 1'b0;
      end else begin
         lock_err <= 1'b0;
         if (!enable) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            freq_valid <= 1'b0;
         end else if (state == ST_IDLE) begin
            // First edge only starts the measurement; no period exists yet.
            cnt <= '0;
            if (edge_p) begin
               state <= ST_ARMED;
            end
         end else if (edge_p) begin
            cnt    <= '0;
            period <= meas;
            case (state)
               ST_ARMED: begin
                  if (hit_any) begin
                     cand  <= hit_code;
                     state <= ST_CONFIRM;
                  end
               end
               ST_CONFIRM: begin
                  if (!hit_any) begin
                     state <= ST_ARMED;
                  end else if (hit_code == cand) begin
                     code_q     <= cand;
                     freq_valid <= 1'b1;
                     state      <= ST_LOCKED;
                  end else begin
                     cand <= hit_code;
                  end
               end
               ST_LOCKED: begin
                  if (!(hit_any && (hit_code == code_q))) begin
                     state      <= ST_ARMED;
                     freq_valid <= 1'b0;
                     lock_err   <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end else if (timeout) begin
            // Input stalled: drop back and wait for a fresh first edge.
            state      <= ST_IDLE;
            cnt        <= '0;
            freq_valid <= 1'b0;
            lock_err   <= (state == ST_LOCKED);
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_blink_freq_detect.sv
// Scoreboard bench for blink_freq_detect at CLK_HZ=10000, TOL_SHIFT=3.
// Honors BLINK_DET_DEGLITCH_EN for pipeline latency and the glitch scenario.
module tb_blink_freq_detect;

   localparam int unsigned CLK_HZ    = 10000;
   localparam int unsigned TOL_SHIFT = 3;
   localparam int          TIMEOUT   = 15000;
`ifdef BLINK_DET_DEGLITCH_EN
   localparam int          LAT       = 6;
`else
   localparam int          LAT       = 4;
`endif

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        enable = 1'b0;
   logic        sig_in = 1'b0;
   logic [1:0]  freq_code;
   logic        freq_valid;
   logic [26:0] period;
   logic        lock_err;

   typedef struct {
      int         due;
      logic       valid;
      logic [1:0] code;
      int         per;
      logic       lerr;
      string      tag;
   } exp_t;

   exp_t       sb[$];
   exp_t       mon_e;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;
   int         m_state = 0;      // 0 idle, 1 armed, 2 confirm, 3 locked
   logic [1:0] m_cand = 2'b00;
   logic [1:0] m_code = 2'b00;
   logic       m_valid = 1'b0;
   int         m_period = 0;
   int         last_rise = 0;
   int         last_proc = 0;
   int         exp_lerr_cnt = 0;
   int         dut_lerr_cnt = 0;

   blink_freq_detect #(
      .CLK_HZ    (CLK_HZ),
      .TOL_SHIFT (TOL_SHIFT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .sig_in     (sig_in),
      .freq_code  (freq_code),
      .freq_valid (freq_valid),
      .period     (period),
      .lock_err   (lock_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic void classify(input int p, output bit hit, output logic [1:0] k);
      hit = 1'b1;
      k   = 2'b00;
      if (p >= 8750 && p <= 11250)     k = 2'b00;
      else if (p >= 875 && p <= 1125)  k = 2'b01;
      else if (p >= 175 && p <= 225)   k = 2'b10;
      else if (p >= 88 && p <= 112)    k = 2'b11;
      else                             hit = 1'b0;
   endfunction

   task automatic push_exp(input int due, input logic lerr, input string tag);
      exp_t e;
      e.due   = due;
      e.valid = m_valid;
      e.code  = m_code;
      e.per   = m_period;
      e.lerr  = lerr;
      e.tag   = tag;
      if (lerr) exp_lerr_cnt++;
      sb.push_back(e);
   endtask

   // Reference behaviour for one rising pin edge, driven at the current cycle.
   task automatic model_edge(input string tag);
      int         gap;
      bit         hit;
      logic [1:0] k;
      logic       lerr;
      gap  = cyc - last_rise;
      lerr = 1'b0;
      last_rise = cyc;
      last_proc = cyc + LAT;
      if (m_state == 0) begin
         m_state = 1;
      end else begin
         m_period = gap;
         classify(gap, hit, k);
         case (m_state)
            1: if (hit) begin m_cand = k; m_state = 2; end
            2: begin
               if (!hit) m_state = 1;
               else if (k == m_cand) begin m_code = k; m_valid = 1'b1; m_state = 3; end
               else m_cand = k;
            end
            default: begin
               if (!(hit && k == m_code)) begin m_state = 1; m_valid = 1'b0; lerr = 1'b1; end
            end
         endcase
      end
      push_exp(cyc + LAT, lerr, tag);
   endtask

   task automatic run_wave(input int per, input int n, input string tag, input bit glitch);
      int hi;
      int q;
      hi = per / 2;
      q  = per / 4;
      for (int i = 0; i < n; i++) begin
         sig_in = 1'b1;
         model_edge(tag);
         if (glitch) begin
            repeat (q) @(negedge clk);
            sig_in = 1'b0;
            repeat (2) @(negedge clk);
            sig_in = 1'b1;
            repeat (hi - q - 2) @(negedge clk);
            sig_in = 1'b0;
            repeat (q) @(negedge clk);
            sig_in = 1'b1;
            repeat (2) @(negedge clk);
            sig_in = 1'b0;
            repeat (per - hi - q - 2) @(negedge clk);
         end else begin
            repeat (hi) @(negedge clk);
            sig_in = 1'b0;
            repeat (per - hi) @(negedge clk);
         end
      end
   endtask

   task automatic hold_low(input int cycles);
      logic lerr;
      sig_in = 1'b0;
      if (m_state != 0) begin
         lerr    = (m_state == 3);
         m_state = 0;
         m_valid = 1'b0;
         push_exp(last_proc + TIMEOUT + 1, lerr, "timeout");
      end
      repeat (cycles) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (rst_n && lock_err === 1'b1) dut_lerr_cnt++;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         mon_e = sb.pop_front();
         check_eq({mon_e.tag, "_due"},   32'(cyc), 32'(mon_e.due));
         check_eq({mon_e.tag, "_valid"}, 32'(freq_valid), 32'(mon_e.valid));
         check_eq({mon_e.tag, "_code"},  32'(freq_code), 32'(mon_e.code));
         check_eq({mon_e.tag, "_period"}, 32'(period), 32'(mon_e.per));
         check_eq({mon_e.tag, "_lerr"},  32'(lock_err), 32'(mon_e.lerr));
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation exceeded 90000 cycles");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("rst_valid",  32'(freq_valid), 32'd0);
      check_eq("rst_code",   32'(freq_code),  32'd0);
      check_eq("rst_period", 32'(period),     32'd0);
      check_eq("rst_lerr",   32'(lock_err),   32'd0);
      rst_n  = 1'b1;
      enable = 1'b1;
      repeat (2) @(negedge clk);

      run_wave(200,   5, "f50",  1'b0);
      run_wave(1000,  4, "f10",  1'b0);
      run_wave(100,   4, "f100", 1'b0);
      run_wave(10000, 4, "f1",   1'b0);
      hold_low(15000);
      run_wave(150,   8, "oob",  1'b0);
      run_wave(100,   4, "pre_en", 1'b0);

      // Drop enable while locked; valid clears on the following cycle.
      enable  = 1'b0;
      m_state = 0;
      m_valid = 1'b0;
      push_exp(cyc + 1, 1'b0, "en_off");
      repeat (5) @(negedge clk);
      enable = 1'b1;
      repeat (5) @(negedge clk);
      run_wave(100, 4, "en_relock", 1'b0);

      // Asynchronous reset while locked clears outputs without a clock edge.
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_valid",  32'(freq_valid), 32'd0);
      check_eq("arst_period", 32'(period),     32'd0);
      check_eq("arst_code",   32'(freq_code),  32'd0);
      check_eq("arst_lerr",   32'(lock_err),   32'd0);
      m_state  = 0;
      m_valid  = 1'b0;
      m_code   = 2'b00;
      m_cand   = 2'b00;
      m_period = 0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      run_wave(100, 4, "rst_relock", 1'b0);

`ifdef BLINK_DET_DEGLITCH_EN
      run_wave(200, 4, "g_pre",  1'b0);
      run_wave(200, 6, "glitch", 1'b1);
`endif

      repeat (LAT + 4) @(negedge clk);
      check_eq("sb_empty", 32'(sb.size()), 32'd0);
      check_eq("lock_err_pulses", 32'(dut_lerr_cnt), 32'(exp_lerr_cnt));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/blink_freq_detect.md
BLINK_FREQ_DETECT -- requirements
Module: blink_freq_detect

Interface
REQ-001 Parameter CLK_HZ, default 50000000: clock frequency in Hz; nominal periods are P0=CLK_HZ, P1=CLK_HZ/10, P2=CLK_HZ/50 and P3=CLK_HZ/100 cycles.
REQ-002 Parameter TOL_SHIFT, default 3: band tolerance for code k is Pk>>TOL_SHIFT cycles.
REQ-003 Port clk, input, 1: single clock; all logic is on its rising edge.
REQ-004 Port rst_n, input, 1: asynchronous active-low reset.
REQ-005 Port enable, input, 1: detector run enable.
REQ-006 Port sig_in, input, 1: asynchronous square wave under test (blinker LED output).
REQ-007 Port freq_code, output, 2: detected rate; 00=1 Hz, 01=10 Hz, 10=50 Hz, 11=100 Hz (same encoding as {switch1,switch2}).
REQ-008 Port freq_valid, output, 1: freq_code is locked and trustworthy.
REQ-009 Port period, output, 27: last measured rising-edge-to-rising-edge period in clk cycles.
REQ-010 Port lock_err, output, 1: one-cycle pulse on loss of lock.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge on the synchronized signal SHALL generate a 1-cycle pulse edge_p, 3 cycles after the pin transition.
REQ-012 Counter cnt (27 b) SHALL increment every non-IDLE cycle; on edge_p: period<=cnt+1, cnt<=0.
REQ-013 cnt SHALL saturate at TIMEOUT=(3*CLK_HZ)/2; reaching TIMEOUT is a timeout event.
REQ-014 Classification: a period is in band k if |period-Pk| <= Pk>>TOL_SHIFT; the bands are disjoint; a period matching no band is "out of band".
REQ-015 FSM states: IDLE, ARMED, CONFIRM, LOCKED.
REQ-016 IDLE: cnt held at 0; on edge_p with enable=1 -> ARMED, with no period capture.
REQ-017 ARMED: an in-band edge stores cand=k and moves to CONFIRM; an out-of-band edge stays in ARMED.
REQ-018 CONFIRM: an edge in band cand -> LOCKED with freq_code<=cand and freq_valid<=1; an edge in a different band stays in CONFIRM with cand updated; an out-of-band edge -> ARMED.
REQ-019 LOCKED: an edge in band freq_code stays in LOCKED; any other edge -> ARMED with freq_valid<=0 and a lock_err pulse.
REQ-020 A timeout in ARMED, CONFIRM or LOCKED SHALL move to IDLE with freq_valid<=0; lock_err pulses only if the state was LOCKED.
REQ-021 If edge_p and timeout occur in the same cycle, edge_p SHALL take priority.
REQ-022 enable=0 SHALL force IDLE on the next cycle, with freq_valid<=0, cnt<=0, no lock_err and period held.
REQ-023 All outputs SHALL be registered and update on the cycle after edge_p.

Reset
REQ-024 rst_n=0 SHALL asynchronously set: state=IDLE, cnt=0, period=0, cand=00, freq_code=00, freq_valid=0, lock_err=0, synchronizer flops=0.
REQ-025 Reset mid-measurement SHALL discard any partial period; after rst_n deasserts, the detector SHALL need 3 edges to lock.

Configuration
REQ-026 With BLINK_DET_DEGLITCH_EN defined, the synchronized signal SHALL change only after 3 consecutive equal samples, adding 2 cycles of latency and rejecting pulses of 2 cycles or fewer.
REQ-027 Without BLINK_DET_DEGLITCH_EN, there is no filter and the latency is as in REQ-011.

Structure
REQ-028 Package blink_pkg SHALL hold the freq_code typedef (FREQ_1HZ..FREQ_100HZ), the FSM state typedef, and the divisor constants 1/10/50/100.
REQ-029 Sub-module blink_edge_sync SHALL contain the synchronizer, the optional deglitch filter and the edge pulse; classification and the FSM SHALL stay in the top module.

Verification (CLK_HZ=10000, TOL_SHIFT=3: bands 8750-11250, 875-1125, 175-225, 88-112; TIMEOUT=15000)
REQ-030 A 200-cycle square wave SHALL give freq_valid=1 and freq_code=10 one cycle after the 3rd rising edge, with period=200.
REQ-031 Locked at 1000 cycles, a switch to 100 cycles SHALL give a lock_err pulse and freq_valid=0 at the next edge, then a relock with code 11 two edges later.
REQ-032 Locked at 10000 cycles, holding sig_in low for 15000 cycles SHALL give IDLE, freq_valid=0 and one lock_err pulse.
REQ-033 A 150-cycle period (out of band) SHALL leave freq_valid at 0 indefinitely and the FSM cycling in ARMED.
REQ-034 Deasserting rst_n or enable while LOCKED at 100 cycles SHALL clear freq_valid (rst_n: immediately; enable: next cycle), with relock taking 3 edges after release.
REQ-035 With BLINK_DET_DEGLITCH_EN, 2-cycle glitches injected into a 200-cycle wave SHALL leave the lock at code 10 with no lock_err pulse.
